// File: rtl/jellyvl_divider_multicycle.sv
// jellyvl_divider_multicycle: multi-cycle restoring divider that resolves STEP_BITS
// quotient bits per enabled clock. Signed operands are divided as magnitudes and
// sign-corrected in one extra cycle.
// Optional macro JELLYVL_DIVIDER_DIVZERO_EN: a zero divisor skips the iteration and
// raises m_div0; without it m_div0 is tied low and the full latency is used.
module jellyvl_divider_multicycle #(
  parameter int DIVIDEND_WIDTH  = 32,
  parameter int DIVISOR_WIDTH   = 32,
  parameter int QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int REMAINDER_WIDTH = DIVISOR_WIDTH,
  parameter int STEP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cke,
  input  logic [DIVIDEND_WIDTH-1:0]  s_dividend,
  input  logic [DIVISOR_WIDTH-1:0]   s_divisor,
  input  logic                       s_signed,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [QUOTIENT_WIDTH-1:0]  m_quotient,
  output logic [REMAINDER_WIDTH-1:0] m_remainder,
  output logic                       m_div0,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int N  = QUOTIENT_WIDTH / STEP_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef JELLYVL_DIVIDER_DIVZERO_EN
  localparam bit DIVZERO_EN = 1'b1;
`else
  localparam bit DIVZERO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CW-1:0]               count;
  logic [QUOTIENT_WIDTH-1:0]   quo;           // dividend shifts out, quotient shifts in
  logic [DIVISOR_WIDTH-1:0]    rem;           // partial remainder magnitude
  logic [DIVISOR_WIDTH-1:0]    divisor_mag;
  logic [DIVIDEND_WIDTH-1:0]   dividend_raw;  // kept for the divide-by-zero remainder
  logic                        neg_quo;
  logic                        neg_rem;
  logic                        is_signed;
  logic                        div0;

  // operand decode at the input port
  logic                        dvd_neg;
  logic                        dvs_neg;
  logic [DIVIDEND_WIDTH-1:0]   dvd_mag;
  logic [DIVISOR_WIDTH-1:0]    dvs_mag;
  logic                        divisor_zero;

  assign dvd_neg      = s_signed & s_dividend[DIVIDEND_WIDTH-1];
  assign dvs_neg      = s_signed & s_divisor[DIVISOR_WIDTH-1];
  assign dvd_mag      = dvd_neg ? -s_dividend : s_dividend;
  assign dvs_mag      = dvs_neg ? -s_divisor : s_divisor;
  assign divisor_zero = (s_divisor == '0);

  // chain of STEP_BITS restoring subtract-shift stages evaluated in one cycle
  logic [DIVISOR_WIDTH-1:0]  rem_stage [0:STEP_BITS];
  logic [QUOTIENT_WIDTH-1:0] quo_stage [0:STEP_BITS];

  assign rem_stage[0] = rem;
  assign quo_stage[0] = quo;

  generate
    for (genvar gi = 0; gi < STEP_BITS; gi++) begin : g_step
      logic [DIVISOR_WIDTH:0] rem_sh;
      logic                   ge;
      assign rem_sh = {rem_stage[gi], quo_stage[gi][QUOTIENT_WIDTH-1]};
      assign ge     = (rem_sh >= {1'b0, divisor_mag});
      // when ge holds the true difference is below the divisor, so the low bits suffice
      assign rem_stage[gi+1] = ge ? (rem_sh[DIVISOR_WIDTH-1:0] - divisor_mag)
                                  : rem_sh[DIVISOR_WIDTH-1:0];
      assign quo_stage[gi+1] = {quo_stage[gi][QUOTIENT_WIDTH-2:0], ge};
    end
  endgenerate

  // sign correction of the magnitude results
  logic [QUOTIENT_WIDTH-1:0]  quo_fix;
  logic [DIVISOR_WIDTH:0]     rem_signed;
  logic [REMAINDER_WIDTH-1:0] rem_fix;
  logic [REMAINDER_WIDTH-1:0] rem_div0;

  assign quo_fix    = neg_quo ? -quo : quo;
  assign rem_signed = neg_rem ? -{1'b0, rem} : {1'b0, rem};
  assign rem_fix    = REMAINDER_WIDTH'($signed(rem_signed));
  assign rem_div0   = is_signed ? REMAINDER_WIDTH'($signed(dividend_raw))
                                : REMAINDER_WIDTH'(dividend_raw);

  // state register, frozen while cke is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (cke) begin
      state <= state_next;
    end
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (s_valid) state_next = (DIVZERO_EN && divisor_zero) ? FIX : BUSY;
      BUSY: if (count == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s_ready = (state == IDLE);
  assign m_valid = (state == DONE);

  // datapath: capture operands, iterate, then register the corrected result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      quo          <= '0;
      rem          <= '0;
      divisor_mag  <= '0;
      dividend_raw <= '0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      is_signed    <= 1'b0;
      div0         <= 1'b0;
      m_quotient   <= '0;
      m_remainder  <= '0;
    end else if (cke) begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            count        <= CW'(N - 1);
            quo          <= QUOTIENT_WIDTH'(dvd_mag);
            rem          <= '0;
            divisor_mag  <= dvs_mag;
            dividend_raw <= s_dividend;
            neg_quo      <= dvd_neg ^ dvs_neg;
            neg_rem      <= dvd_neg;
            is_signed    <= s_signed;
            div0         <= divisor_zero;
          end
        end
        BUSY: begin
          quo   <= quo_stage[STEP_BITS];
          rem   <= rem_stage[STEP_BITS];
          count <= count - 1'b1;
        end
        FIX: begin
          m_quotient  <= div0 ? '1 : quo_fix;
          m_remainder <= div0 ? rem_div0 : rem_fix;
        end
        default: ;
      endcase
    end
  end

`ifdef JELLYVL_DIVIDER_DIVZERO_EN
  logic div0_out;

  // divide-by-zero flag published with the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div0_out <= 1'b0;
    end else if (cke && state == FIX) begin
      div0_out <= div0;
    end
  end

  assign m_div0 = div0_out;
`else
  assign m_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_jellyvl_divider_multicycle.sv
// Self-checking bench for jellyvl_divider_multicycle (32/32 bits, STEP_BITS=4).
module tb_jellyvl_divider_multicycle;

  localparam int STEP = 4;
  localparam int NQ   = 32 / STEP;

`ifdef JELLYVL_DIVIDER_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cke = 1'b1;
  logic [31:0] s_dividend = '0;
  logic [31:0] s_divisor  = '0;
  logic        s_signed   = 1'b0;
  logic        s_valid    = 1'b0;
  logic        s_ready;
  logic [31:0] m_quotient;
  logic [31:0] m_remainder;
  logic        m_div0;
  logic        m_valid;
  logic        m_ready = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cke_mode  = 0;  // 0: always enabled, 1: random 50%, 2: held low

  jellyvl_divider_multicycle #(
    .DIVIDEND_WIDTH (32),
    .DIVISOR_WIDTH  (32),
    .QUOTIENT_WIDTH (32),
    .REMAINDER_WIDTH(32),
    .STEP_BITS      (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cke        (cke),
    .s_dividend (s_dividend),
    .s_divisor  (s_divisor),
    .s_signed   (s_signed),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_quotient (m_quotient),
    .m_remainder(m_remainder),
    .m_div0     (m_div0),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  // clock-enable driver, updated 2 time units after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (cke_mode)
        0:       cke = 1'b1;
        1:       cke = 1'($urandom_range(0, 1));
        default: cke = 1'b0;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // reference: plain integer division following the divider's result rules
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // present operands and wait for the accepting (enabled) edge; tasks run at posedge+1
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sg);
    bit ok = 0;
    for (int i = 0; i < 400 && !s_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before_accept", s_ready, 1);
    s_dividend = a;
    s_divisor  = b;
    s_signed   = sg;
    s_valid    = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      if (cke) ok = 1;
    end
    #1;
    s_valid    = 1'b0;
    s_dividend = $urandom;
    s_divisor  = $urandom;
    s_signed   = 1'($urandom_range(0, 1));
    check("accepted", {ok, s_ready}, 2'b10);
  endtask

  // count enabled edges (accept edge = 1) until m_valid
  task automatic wait_result(output int lat);
    bit got = 0;
    lat = 1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      if (cke) lat++;
      #1;
      if (m_valid) got = 1;
    end
    if (!got) begin
      check("result_timeout", 0, 1);
      lat = -1;
    end
  endtask

  // stall randomly while checking hold, then complete the output handshake
  task automatic finish_op(input logic [31:0] q0, input logic [31:0] r0, input logic d0);
    int stall = $urandom_range(0, 3);
    bit bad = 0;
    bit got = 0;
    m_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      #1;
      if (!m_valid || m_quotient !== q0 || m_remainder !== r0 || m_div0 !== d0) bad = 1;
    end
    check("hold_while_stalled", bad, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      if (cke) got = 1;
    end
    #1;
    m_ready = 1'b0;
    check("release", {got, s_ready, m_valid}, 3'b110);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [31:0] eq, input logic [31:0] er);
    int lat;
    int exp_lat = (b == 0 && DZ_EN) ? 2 : NQ + 2;
    logic exp_d0 = (b == 0) && DZ_EN;
    start_op(a, b, sg);
    wait_result(lat);
    check({tag, "_quotient"}, m_quotient, eq);
    check({tag, "_remainder"}, m_remainder, er);
    check({tag, "_div0"}, m_div0, exp_d0);
    check({tag, "_latency"}, lat, exp_lat);
    $display("%s: %h/%h s=%0d -> q=%h r=%h d0=%0d lat=%0d", tag, a, b, sg,
             m_quotient, m_remainder, m_div0, lat);
    finish_op(eq, er, exp_d0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat;
    logic [31:0] a, b, eq, er;
    logic sg;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1] = '{-32'sd7,        32'd2,          1'b1, -32'sd3,        -32'sd1};
    vecs[2] = '{32'd7,          -32'sd2,        1'b1, -32'sd3,        32'd1};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
    vecs[4] = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5};
    vecs[5] = '{-32'sd5,        32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[6] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
    vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
    vecs[8] = '{32'd0,          32'd7,          1'b1, 32'd0,          32'd0};
    vecs[9] = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0};

    // reset state, asserted from time zero
    #12;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_div0", m_div0, 0);
    check("rst_m_quotient", m_quotient, 0);
    check("rst_m_remainder", m_remainder, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg,
                             vecs[i].q, vecs[i].r);

    // reset in the middle of an operation, with cke held low
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    cke_mode = 2;
    #3;
    rst = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_m_quotient", m_quotient, 0);
    $display("midrst: reset asserted during BUSY, s_ready=%0d m_valid=%0d", s_ready, m_valid);
    cke_mode = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // s_valid held through DONE must not be accepted until IDLE
    start_op(32'd50, 32'd6, 1'b0);
    wait_result(lat);
    check("done_q", m_quotient, 32'd8);
    check("done_r", m_remainder, 32'd2);
    s_dividend = 32'd77;
    s_divisor  = 32'd10;
    s_signed   = 1'b0;
    s_valid    = 1'b1;
    m_ready    = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("done_no_accept", {s_ready, m_valid}, 2'b10);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("accept_from_idle", s_ready, 0);
    wait_result(lat);
    check("held_q", m_quotient, 32'd7);
    check("held_r", m_remainder, 32'd7);
    check("held_latency", lat, NQ + 2);
    $display("held: 77/10 -> q=%h r=%h lat=%0d", m_quotient, m_remainder, lat);
    finish_op(32'd7, 32'd7, 1'b0);

    // randomized operands, first with cke toggling, then fully enabled
    for (int i = 0; i < 300; i++) begin
      cke_mode = (i < 100) ? 1 : 0;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(0, 4));
        1: b = -32'($urandom_range(1, 4));
        2: b = b >> $urandom_range(1, 30);
        3: a = 32'h8000_0000;
        default: ;
      endcase
      model(a, b, sg, eq, er);
      run_op($sformatf("rnd%0d", i), a, b, sg, eq, er);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
